// File: rtl/cache_axi_pkg.sv
// Shared types and AXI3 constants for the cache-to-AXI arbiter.
// Holds the FSM state encoding and the fixed burst attributes used on both address channels.
package cache_axi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW,
        S_W,
        S_B
    } state_t;

    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [3:0] ID_INST    = 4'd0;
    localparam logic [3:0] ID_DATA    = 4'd1;

    // Clears the byte offset within a line of line_words 32-bit words.
    function automatic logic [31:0] line_mask(input int line_words);
        return ~((32'd1 << ($clog2(line_words) + 2)) - 32'd1);
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin picker; on a tie the side not granted last wins.
// The last-grant register moves only when i_update is high and something is granted.
module arb_rr2 (
    input  logic clk,
    input  logic rst,
    input  logic i_req_inst,
    input  logic i_req_data,
    input  logic i_update,
    output logic o_gnt_inst,
    output logic o_gnt_data
);

    logic r_last_data;

    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        o_gnt_inst = 1'b0;
        o_gnt_data = 1'b0;
        if (i_req_inst && i_req_data) begin
            o_gnt_data = !r_last_data;
            o_gnt_inst = r_last_data;
        end else begin
            o_gnt_inst = i_req_inst;
            o_gnt_data = i_req_data;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_last_data <= 1'b0;
        end else if (i_update && (o_gnt_inst || o_gnt_data)) begin
            r_last_data <= o_gnt_data;
        end
    end

endmodule

// File: rtl/cache_axi_arbiter.sv
// Shares one AXI3 master port between the instruction-cache refill path and the
// data-cache refill/write-back path, one burst at a time, round-robin on ties.
module cache_axi_arbiter
    import cache_axi_pkg::*;
#(
    parameter int LINE_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    output logic        i_rvalid,
    output logic        i_rlast,

    input  logic        d_req,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_rvalid,
    output logic        d_rlast,
    input  logic [31:0] d_wdata,
    output logic        d_wnext,
    output logic        d_bdone,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,

    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    localparam logic [3:0]  BURST_LEN = 4'(LINE_WORDS - 1);
    localparam logic [31:0] ADDR_MASK = line_mask(LINE_WORDS);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_owner_data;
    logic        r_is_wr;
    logic [31:0] r_addr;
    logic [3:0]  r_cnt;

    logic        w_can_grant;
    logic        w_gnt_inst;
    logic        w_gnt_data;
    logic        w_granted;
    logic        w_r_phase;

    // Responses and IDs are deliberately ignored: only one burst is ever in flight.
    logic        w_unused_resp;
    assign w_unused_resp = ^{rid, rresp, bid, bresp};

    // Reset masks the grant so no ack escapes while the block is held in reset.
    assign w_can_grant = (r_state == S_IDLE) && !rst;
    assign w_granted   = w_can_grant && (w_gnt_inst || w_gnt_data);

    arb_rr2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .i_req_inst (i_req),
        .i_req_data (d_req),
        .i_update   (w_can_grant),
        .o_gnt_inst (w_gnt_inst),
        .o_gnt_data (w_gnt_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner_data <= 1'b0;
            r_is_wr      <= 1'b0;
            r_addr       <= 32'd0;
            r_cnt        <= 4'd0;
        end else begin
            r_state <= w_next_state;
            if (w_granted) begin
                r_owner_data <= w_gnt_data;
                r_is_wr      <= w_gnt_data && d_wr;
                r_addr       <= (w_gnt_data ? d_addr : i_addr) & ADDR_MASK;
            end
            if (r_state == S_AW && awready) begin
                r_cnt <= 4'd0;
            end else if (r_state == S_W && wready) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    assign w_r_phase = (r_state == S_R);

    always_comb begin
        w_next_state = r_state;

        i_ack    = 1'b0;
        d_ack    = 1'b0;
        i_rdata  = 32'd0;
        i_rvalid = 1'b0;
        i_rlast  = 1'b0;
        d_rdata  = 32'd0;
        d_rvalid = 1'b0;
        d_rlast  = 1'b0;
        d_wnext  = 1'b0;
        d_bdone  = 1'b0;

        arid     = 4'd0;
        araddr   = 32'd0;
        arlen    = 4'd0;
        arsize   = 3'd0;
        arburst  = 2'd0;
        arvalid  = 1'b0;
        rready   = 1'b0;
        awid     = 4'd0;
        awaddr   = 32'd0;
        awlen    = 4'd0;
        awsize   = 3'd0;
        awburst  = 2'd0;
        awvalid  = 1'b0;
        wdata    = 32'd0;
        wstrb    = 4'd0;
        wlast    = 1'b0;
        wvalid   = 1'b0;
        bready   = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                i_ack = w_can_grant && w_gnt_inst;
                d_ack = w_can_grant && w_gnt_data;
                if (w_granted) begin
                    w_next_state = (w_gnt_data && d_wr) ? S_AW : S_AR;
                end
            end
            S_AR: begin
                arvalid = 1'b1;
                arid    = r_owner_data ? ID_DATA : ID_INST;
                araddr  = r_addr;
                arlen   = BURST_LEN;
                arsize  = SIZE_4B;
                arburst = BURST_INCR;
                if (arready) begin
                    w_next_state = S_R;
                end
            end
            S_R: begin
                rready = 1'b1;
                if (rvalid && rlast) begin
                    w_next_state = S_IDLE;
                end
            end
            S_AW: begin
                awvalid = 1'b1;
                awid    = ID_DATA;
                awaddr  = r_addr;
                awlen   = BURST_LEN;
                awsize  = SIZE_4B;
                awburst = BURST_INCR;
                if (awready) begin
                    w_next_state = S_W;
                end
            end
            S_W: begin
                wvalid  = 1'b1;
                wdata   = d_wdata;
                wstrb   = 4'hF;
                wlast   = (r_cnt == BURST_LEN);
                d_wnext = wready;
                if (wready && wlast) begin
                    w_next_state = S_B;
                end
            end
            S_B: begin
                bready  = 1'b1;
                d_bdone = bvalid;
                if (bvalid) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        // Read data is steered combinationally to whichever cache owns the burst.
        if (w_r_phase) begin
            if (r_owner_data) begin
                d_rdata  = rdata;
                d_rvalid = rvalid;
                d_rlast  = rlast;
            end else begin
                i_rdata  = rdata;
                i_rvalid = rvalid;
                i_rlast  = rlast;
            end
        end
    end

    // r_is_wr is kept for debug visibility of the granted operation.
    logic w_unused_wr;
    assign w_unused_wr = r_is_wr;

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed bench for cache_axi_arbiter (LINE_WORDS = 8): inputs change and outputs
// are sampled just after the falling edge, away from the active rising edge.
module tb_cache_axi_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_rvalid;
    logic        i_rlast;
    logic        d_req;
    logic        d_wr;
    logic [31:0] d_addr;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_rvalid;
    logic        d_rlast;
    logic [31:0] d_wdata;
    logic        d_wnext;
    logic        d_bdone;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cache_axi_arbiter #(.LINE_WORDS(8)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
        .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_rlast(i_rlast),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_ack(d_ack),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_rlast(d_rlast),
        .d_wdata(d_wdata), .d_wnext(d_wnext), .d_bdone(d_bdone),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, then let combinational outputs settle.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    // Eight read beats with rdata = base + k; rlast on the eighth.
    task automatic read_burst(input logic [31:0] base, input logic to_data);
        for (int k = 0; k < 8; k++) begin
            rvalid = 1'b1;
            rdata  = base + 32'(k);
            rlast  = (k == 7);
            settle();
            check("rready", rready, 1'b1);
            check(to_data ? "d_rvalid" : "i_rvalid", to_data ? d_rvalid : i_rvalid, 1'b1);
            check(to_data ? "i_rvalid_off" : "d_rvalid_off", to_data ? i_rvalid : d_rvalid, 1'b0);
            check(to_data ? "d_rdata" : "i_rdata", to_data ? d_rdata : i_rdata, base + 32'(k));
            check(to_data ? "d_rlast" : "i_rlast", to_data ? d_rlast : i_rlast, 32'(k == 7));
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rdata  = 32'd0;
    endtask

    initial begin
        int beat;
        int wnexts;
        int guard;
        logic wr_toggle;

        rst = 1'b1;
        i_req = 1'b0; i_addr = 32'd0;
        d_req = 1'b0; d_wr = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b0; rvalid = 1'b0;
        bid = 4'd0; bresp = 2'd0; bvalid = 1'b0;

        tick(); tick();
        settle();
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_rready", rready, 1'b0);
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_bready", bready, 1'b0);
        check("rst_araddr", araddr, 32'd0);
        check("rst_i_ack", i_ack, 1'b0);
        rst = 1'b0;
        tick();

        // Lone instruction refill, acked in the request cycle.
        i_req = 1'b1; i_addr = 32'h1fc0_0014;
        settle();
        check("t1_i_ack", i_ack, 1'b1);
        check("t1_d_ack", d_ack, 1'b0);
        check("t1_arvalid_ack_cycle", arvalid, 1'b0);
        tick();
        i_req = 1'b0;
        arready = 1'b1;
        settle();
        check("t1_i_ack_gone", i_ack, 1'b0);
        check("t1_arvalid", arvalid, 1'b1);
        check("t1_araddr", araddr, 32'h1fc0_0000);
        check("t1_arlen", arlen, 4'd7);
        check("t1_arid", arid, 4'd0);
        check("t1_arsize", arsize, 3'b010);
        check("t1_arburst", arburst, 2'b01);
        check("t1_rready_ar", rready, 1'b0);
        tick();
        arready = 1'b0;
        settle();
        check("t1_arvalid_r", arvalid, 1'b0);
        // A data request raised and dropped while busy must never be granted.
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h0000_1234;
        settle();
        check("t1_busy_d_ack", d_ack, 1'b0);
        read_burst(32'h0000_a000, 1'b0);
        d_req = 1'b0;
        settle();
        check("t1_idle_rready", rready, 1'b0);
        check("t1_dropped_d_ack", d_ack, 1'b0);
        tick();
        settle();
        check("t1_dropped_arvalid", arvalid, 1'b0);

        // Tie with last grant = inst: data refill wins, inst follows.
        i_req = 1'b1; d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h0000_1234;
        settle();
        check("t2_d_ack", d_ack, 1'b1);
        check("t2_i_ack", i_ack, 1'b0);
        tick();
        d_req = 1'b0;
        arready = 1'b1;
        settle();
        check("t2_arid", arid, 4'd1);
        check("t2_araddr", araddr, 32'h0000_1220);
        check("t2_i_ack_busy", i_ack, 1'b0);
        tick();
        arready = 1'b0;
        read_burst(32'h0000_b000, 1'b1);
        settle();
        check("t2_i_ack_follows", i_ack, 1'b1);
        tick();
        i_req = 1'b0;

        // Address stall: arvalid/araddr must hold and no read handshake happens.
        for (int c = 0; c < 5; c++) begin
            settle();
            check("t3_stall_arvalid", arvalid, 1'b1);
            check("t3_stall_araddr", araddr, 32'h1fc0_0000);
            check("t3_stall_rready", rready, 1'b0);
            tick();
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        read_burst(32'h0000_c000, 1'b0);

        // Tie again (last = inst): data write-back wins.
        i_req = 1'b1; d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h8000_0040;
        settle();
        check("t4_d_ack", d_ack, 1'b1);
        check("t4_i_ack", i_ack, 1'b0);
        tick();
        d_req = 1'b0;
        awready = 1'b1;
        settle();
        check("t4_awvalid", awvalid, 1'b1);
        check("t4_awaddr", awaddr, 32'h8000_0040);
        check("t4_awid", awid, 4'd1);
        check("t4_awlen", awlen, 4'd7);
        check("t4_arvalid", arvalid, 1'b0);
        tick();
        awready = 1'b0;

        beat = 0; wnexts = 0; guard = 0; wr_toggle = 1'b0;
        while (beat < 8 && guard < 40) begin
            d_wdata = 32'(beat);
            wready  = wr_toggle;
            settle();
            check("t4_wvalid", wvalid, 1'b1);
            check("t4_wdata", wdata, 32'(beat));
            check("t4_wstrb", wstrb, 4'hF);
            check("t4_wlast", wlast, 32'(beat == 7));
            check("t4_wnext", d_wnext, wready);
            if (d_wnext) wnexts++;
            if (wready) beat++;
            wr_toggle = ~wr_toggle;
            guard++;
            tick();
        end
        wready = 1'b0;
        check("t4_beats", 32'(beat), 32'd8);
        check("t4_wnexts", 32'(wnexts), 32'd8);

        for (int c = 0; c < 2; c++) begin
            settle();
            check("t4_bready", bready, 1'b1);
            check("t4_bdone_wait", d_bdone, 1'b0);
            check("t4_wvalid_b", wvalid, 1'b0);
            tick();
        end
        bvalid = 1'b1;
        settle();
        check("t4_bdone", d_bdone, 1'b1);
        tick();
        bvalid = 1'b0;

        // Tie with last grant = data: inst wins.
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h0000_2000;
        settle();
        check("t5_bdone_once", d_bdone, 1'b0);
        check("t5_i_ack", i_ack, 1'b1);
        check("t5_d_ack", d_ack, 1'b0);
        tick();
        i_req = 1'b0; d_req = 1'b0;
        arready = 1'b1;
        settle();
        check("t5_arid", arid, 4'd0);
        tick();
        arready = 1'b0;

        // Reset during the third read beat abandons the burst.
        for (int k = 0; k < 2; k++) begin
            rvalid = 1'b1; rdata = 32'h0000_d000 + 32'(k); rlast = 1'b0;
            settle();
            check("t6_pre_rvalid", i_rvalid, 1'b1);
            tick();
        end
        rdata = 32'h0000_d002;
        settle();
        check("t6_beat3_rvalid", i_rvalid, 1'b1);
        rst = 1'b1;
        tick();
        settle();
        check("t6_rst_rready", rready, 1'b0);
        check("t6_rst_i_rvalid", i_rvalid, 1'b0);
        check("t6_rst_i_rdata", i_rdata, 32'd0);
        check("t6_rst_arvalid", arvalid, 1'b0);
        check("t6_rst_awvalid", awvalid, 1'b0);
        check("t6_rst_wvalid", wvalid, 1'b0);
        check("t6_rst_bready", bready, 1'b0);
        rst = 1'b0;
        rvalid = 1'b0; rdata = 32'd0;
        tick();
        i_req = 1'b1; i_addr = 32'h0000_3004;
        settle();
        check("t6_fresh_i_ack", i_ack, 1'b1);
        check("t6_fresh_d_ack", d_ack, 1'b0);
        tick();
        i_req = 1'b0;
        settle();
        check("t6_fresh_arvalid", arvalid, 1'b1);
        check("t6_fresh_araddr", araddr, 32'h0000_3000);
        check("t6_fresh_rready", rready, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
